// File: rtl/wb_chan_fanout.sv
`default_nettype none
//============================================================================
// Module      : wb_chan_fanout
// Description : Registered Wishbone classic 1-to-NCHAN fan-out for the
//               per-channel trigger-chain configuration space. Decodes a
//               channel index from the upstream address and forwards one
//               transaction at a time to the matching downstream channel.
//               Supports broadcast writes, a per-transaction timeout and an
//               error response for accesses to channels that do not exist.
//
// Ports       : wb_clk_i / wb_rst_i          clock, synchronous active-high reset
//               wb_cyc_i .. wb_sel_i         upstream Wishbone request
//               wb_ack_o / wb_err_o / wb_rty_o  upstream 1-cycle response pulses
//               wb_dat_o                     upstream read data (held)
//               m_cyc_o / m_stb_o            per-channel cycle / strobe
//               m_we_o .. m_sel_o            request fields shared by all channels
//               m_ack_i / m_err_i / m_rty_i  per-channel responses
//               m_dat_i                      per-channel read data, ch k at [32k+31:32k]
//               timeout_cnt_o                saturating count of timeouts
//
// Revision    : 1.0  initial release
//============================================================================
module wb_chan_fanout #(
    parameter int NCHAN     = 8,
    parameter int ADR_W     = 22,
    parameter int SUB_ADR_W = 8,
    parameter int CHAN_LSB  = 10,
    parameter int BCAST_BIT = 14,
    parameter int TIMEOUT   = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [ADR_W-1:0]       wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [31:0]            wb_dat_o,
    output logic [NCHAN-1:0]       m_cyc_o,
    output logic [NCHAN-1:0]       m_stb_o,
    output logic                   m_we_o,
    output logic [SUB_ADR_W-1:0]   m_adr_o,
    output logic [31:0]            m_dat_o,
    output logic [3:0]             m_sel_o,
    input  logic [NCHAN-1:0]       m_ack_i,
    input  logic [NCHAN-1:0]       m_err_i,
    input  logic [NCHAN-1:0]       m_rty_i,
    input  logic [NCHAN*32-1:0]    m_dat_i,
    output logic [7:0]             timeout_cnt_o
);

    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    // One extra bit so that NCHAN itself is representable for the range check.
    localparam logic [CW:0]        c_nchan    = (CW+1)'(NCHAN);
    localparam logic [NCHAN-1:0]   c_one      = NCHAN'(1);
    localparam logic [15:0]        c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                 r_state_q,  w_state_d;
    logic [NCHAN-1:0]       r_pend_q,   w_pend_d;
    logic                   r_we_q,     w_we_d;
    logic [SUB_ADR_W-1:0]   r_adr_q,    w_adr_d;
    logic [31:0]            r_wdat_q,   w_wdat_d;
    logic [3:0]             r_sel_q,    w_sel_d;
    logic [CW-1:0]          r_idx_q,    w_idx_d;
    logic                   r_err_st_q, w_err_st_d;
    logic                   r_rty_st_q, w_rty_st_d;
    logic [15:0]            r_tcnt_q,   w_tcnt_d;
    logic                   r_ack_q,    w_ack_d;
    logic                   r_err_q,    w_err_d;
    logic                   r_rty_q,    w_rty_d;
    logic [31:0]            r_rdat_q,   w_rdat_d;
    logic [7:0]             r_tocnt_q,  w_tocnt_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [CW-1:0]          w_req_idx;
    logic                   w_req_bcast;
    logic                   w_req_valid;
    logic [NCHAN-1:0]       w_req_mask;

    assign w_req_idx   = wb_adr_i[CHAN_LSB +: CW];
    // Broadcast only applies to writes; a read with the bit set is unicast.
    assign w_req_bcast = wb_we_i & wb_adr_i[BCAST_BIT];
    assign w_req_valid = w_req_bcast | ({1'b0, w_req_idx} < c_nchan);
    assign w_req_mask  = w_req_bcast ? {NCHAN{1'b1}} :
                         (w_req_valid ? (c_one << w_req_idx) : '0);

    // ------------------------------------------------------------------
    // Downstream response collection; only channels still pending count.
    // ------------------------------------------------------------------
    logic [NCHAN-1:0]       w_hit;
    logic [NCHAN-1:0]       w_pend_left;
    logic                   w_hit_err;
    logic                   w_hit_rty;
    logic                   w_tmo;
    logic                   w_fin_err;
    logic                   w_fin_rty;

    assign w_hit       = (m_ack_i | m_err_i | m_rty_i) & r_pend_q;
    assign w_pend_left = r_pend_q & ~w_hit;
    assign w_hit_err   = |(m_err_i & r_pend_q);
    assign w_hit_rty   = |(m_rty_i & r_pend_q);
    assign w_tmo       = (r_tcnt_q == c_tmo_last);
    assign w_fin_err   = r_err_st_q | w_hit_err;
    assign w_fin_rty   = r_rty_st_q | w_hit_rty;

    logic [31:0]            w_chan_dat [NCHAN];

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan_dat
        assign w_chan_dat[k] = m_dat_i[32*k +: 32];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_pend_d   = r_pend_q;
        w_we_d     = r_we_q;
        w_adr_d    = r_adr_q;
        w_wdat_d   = r_wdat_q;
        w_sel_d    = r_sel_q;
        w_idx_d    = r_idx_q;
        w_err_st_d = r_err_st_q;
        w_rty_st_d = r_rty_st_q;
        w_tcnt_d   = r_tcnt_q;
        w_ack_d    = 1'b0;
        w_err_d    = 1'b0;
        w_rty_d    = 1'b0;
        w_rdat_d   = r_rdat_q;
        w_tocnt_d  = r_tocnt_q;

        case (r_state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_we_d     = wb_we_i;
                    w_adr_d    = wb_adr_i[SUB_ADR_W-1:0];
                    w_wdat_d   = wb_dat_i;
                    w_sel_d    = wb_sel_i;
                    w_idx_d    = w_req_idx;
                    w_err_st_d = 1'b0;
                    w_rty_st_d = 1'b0;
                    w_tcnt_d   = '0;
                    if (w_req_valid) begin
                        w_pend_d  = w_req_mask;
                        w_state_d = S_ISSUE;
                    end else begin
                        w_err_d   = 1'b1;
                        w_state_d = S_RESP;
                    end
                end
            end

            S_ISSUE: begin
                w_tcnt_d = r_tcnt_q + 16'd1;
                if (!wb_cyc_i) begin
                    // Master gave up: silently release every channel.
                    w_pend_d  = '0;
                    w_state_d = S_IDLE;
                end else if (w_pend_left == '0) begin
                    // Last outstanding channel answered; this also beats an
                    // expiry landing in the same cycle.
                    w_pend_d  = '0;
                    w_state_d = S_RESP;
                    w_err_d   = w_fin_err;
                    w_rty_d   = ~w_fin_err & w_fin_rty;
                    w_ack_d   = ~w_fin_err & ~w_fin_rty;
                    if (!w_fin_err && !w_fin_rty && !r_we_q) begin
                        w_rdat_d = w_chan_dat[r_idx_q];
                    end
                end else if (w_tmo) begin
                    w_pend_d  = '0;
                    w_state_d = S_RESP;
                    w_err_d   = 1'b1;
                    if (r_tocnt_q != 8'hFF) begin
                        w_tocnt_d = r_tocnt_q + 8'd1;
                    end
                end else begin
                    w_pend_d   = w_pend_left;
                    w_err_st_d = r_err_st_q | w_hit_err;
                    w_rty_st_d = r_rty_st_q | w_hit_rty;
                end
            end

            S_RESP: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
                w_pend_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q  <= S_IDLE;
            r_pend_q   <= '0;
            r_we_q     <= 1'b0;
            r_adr_q    <= '0;
            r_wdat_q   <= '0;
            r_sel_q    <= '0;
            r_idx_q    <= '0;
            r_err_st_q <= 1'b0;
            r_rty_st_q <= 1'b0;
            r_tcnt_q   <= '0;
            r_ack_q    <= 1'b0;
            r_err_q    <= 1'b0;
            r_rty_q    <= 1'b0;
            r_rdat_q   <= '0;
            r_tocnt_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pend_q   <= w_pend_d;
            r_we_q     <= w_we_d;
            r_adr_q    <= w_adr_d;
            r_wdat_q   <= w_wdat_d;
            r_sel_q    <= w_sel_d;
            r_idx_q    <= w_idx_d;
            r_err_st_q <= w_err_st_d;
            r_rty_st_q <= w_rty_st_d;
            r_tcnt_q   <= w_tcnt_d;
            r_ack_q    <= w_ack_d;
            r_err_q    <= w_err_d;
            r_rty_q    <= w_rty_d;
            r_rdat_q   <= w_rdat_d;
            r_tocnt_q  <= w_tocnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    assign wb_ack_o      = r_ack_q;
    assign wb_err_o      = r_err_q;
    assign wb_rty_o      = r_rty_q;
    assign wb_dat_o      = r_rdat_q;
    assign m_cyc_o       = r_pend_q;
    assign m_stb_o       = r_pend_q;
    assign m_we_o        = r_we_q;
    assign m_adr_o       = r_adr_q;
    assign m_dat_o       = r_wdat_q;
    assign m_sel_o       = r_sel_q;
    assign timeout_cnt_o = r_tocnt_q;

    // Address bits outside the index, broadcast and sub-address fields are
    // not decoded here.
    logic w_unused;
    assign w_unused = ^wb_adr_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_chan_fanout.sv
`default_nettype none
//============================================================================
// Module      : tb_wb_chan_fanout
// Description : Self-checking bench for wb_chan_fanout (NCHAN=6, TIMEOUT=16).
//               Each transaction is described by per-channel response delay
//               and kind; the expected strobe pattern, response cycle and
//               response kind are derived from those with plain arithmetic.
// Revision    : 1.0  initial release
//============================================================================
module tb_wb_chan_fanout;

    localparam int NCH = 6;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [21:0]       wb_adr = '0;
    logic [31:0]       wb_dat = '0;
    logic [3:0]        wb_sel = '0;
    logic              wb_ack, wb_err, wb_rty;
    logic [31:0]       wb_rdat;
    logic [NCH-1:0]    m_cyc, m_stb;
    logic              m_we;
    logic [7:0]        m_adr;
    logic [31:0]       m_dato;
    logic [3:0]        m_sel;
    logic [NCH-1:0]    m_ack = '0, m_err = '0, m_rty = '0;
    logic [NCH*32-1:0] m_dati = '0;
    logic [7:0]        tocnt;

    always #5 clk = ~clk;

    wb_chan_fanout #(
        .NCHAN(NCH), .ADR_W(22), .SUB_ADR_W(8), .CHAN_LSB(10),
        .BCAST_BIT(14), .TIMEOUT(TO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty), .wb_dat_o(wb_rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_adr_o(m_adr),
        .m_dat_o(m_dato), .m_sel_o(m_sel),
        .m_ack_i(m_ack), .m_err_i(m_err), .m_rty_i(m_rty), .m_dat_i(m_dati),
        .timeout_cnt_o(tocnt)
    );

    int          checks = 0;
    int          errors = 0;

    // Per-transaction downstream behaviour: delay 0 = never responds;
    // kind 0 = ack, 1 = err, 2 = rty. abort_at 0 = master never aborts.
    int          t_dly [NCH];
    int          t_typ [NCH];
    int          t_abort;
    logic [31:0] t_rdat [NCH];

    logic [31:0] exp_dat   = '0;
    int          exp_tocnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cfg();
        for (int k = 0; k < NCH; k++) begin
            t_dly[k]  = 0;
            t_typ[k]  = 0;
            t_rdat[k] = $urandom;
        end
        t_abort = 0;
    endtask

    function automatic logic [21:0] mk_adr(input bit bc, input int idx, input logic [7:0] sub);
        logic [21:0] a;
        a = '0;
        a[14]    = bc;
        a[12:10] = 3'(idx);
        a[7:0]   = sub;
        return a;
    endfunction

    // Called at #1 into the cycle in which the request is presented (cycle 0).
    task automatic run_txn(input bit we, input logic [21:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input bit spur);
        int             idx;
        bit             bcast;
        logic [NCH-1:0] chmask;
        logic [NCH-1:0] exp_stb;
        bit             never, complete, any_err, any_rty;
        int             dmax, stopc, e, outcome;  // outcome: 0 none 1 ack 2 err 3 rty

        idx    = int'(adr[12:10]);
        bcast  = we && adr[14];
        chmask = '0;
        if (bcast) chmask = '1;
        else if (idx < NCH) chmask[idx] = 1'b1;

        if (chmask == '0) begin
            e       = 0;
            outcome = 2;
        end else begin
            never = 0; dmax = 0; any_err = 0; any_rty = 0;
            for (int k = 0; k < NCH; k++) begin
                if (chmask[k]) begin
                    if (t_dly[k] == 0) never = 1;
                    else if (t_dly[k] > dmax) dmax = t_dly[k];
                    if (t_typ[k] == 1) any_err = 1;
                    if (t_typ[k] == 2) any_rty = 1;
                end
            end
            complete = !never && dmax <= TO;
            stopc    = complete ? dmax : TO;
            if (t_abort != 0 && t_abort <= stopc) begin
                e       = t_abort;
                outcome = 0;
            end else begin
                e = stopc;
                if (complete) outcome = any_err ? 2 : (any_rty ? 3 : 1);
                else begin
                    outcome = 2;
                    if (exp_tocnt < 255) exp_tocnt++;
                end
            end
            if (outcome == 1 && !we) exp_dat = t_rdat[idx];
        end

        for (int k = 0; k < NCH; k++) m_dati[32*k +: 32] = t_rdat[k];
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr;  wb_dat = dat;  wb_sel = sel;

        for (int t = 1; t <= e + 2; t++) begin
            @(posedge clk); #1;
            exp_stb = '0;
            for (int k = 0; k < NCH; k++)
                if (chmask[k] && t <= e && (t_dly[k] == 0 || t <= t_dly[k])) exp_stb[k] = 1'b1;
            chk("m_stb_o", 64'(m_stb), 64'(exp_stb));
            chk("m_cyc_o", 64'(m_cyc), 64'(exp_stb));
            chk("wb_ack_o", 64'(wb_ack), 64'(t == e + 1 && outcome == 1));
            chk("wb_err_o", 64'(wb_err), 64'(t == e + 1 && outcome == 2));
            chk("wb_rty_o", 64'(wb_rty), 64'(t == e + 1 && outcome == 3));
            if (t == 1 && chmask != '0) begin
                chk("m_adr_o", 64'(m_adr), 64'(adr[7:0]));
                chk("m_we_o",  64'(m_we),  64'(we));
                chk("m_dat_o", 64'(m_dato), 64'(dat));
                chk("m_sel_o", 64'(m_sel), 64'(sel));
            end
            // Downstream responses for this cycle.
            m_ack = '0; m_err = '0; m_rty = '0;
            for (int k = 0; k < NCH; k++) begin
                if (chmask[k] && t == t_dly[k] && t <= e) begin
                    case (t_typ[k])
                        1:       m_err[k] = 1'b1;
                        2:       m_rty[k] = 1'b1;
                        default: m_ack[k] = 1'b1;
                    endcase
                end else if (!chmask[k] && spur) begin
                    m_ack[k] = 1'($urandom);
                    m_err[k] = 1'($urandom_range(0, 3) == 0);
                end
            end
            if ((t_abort != 0 && t >= t_abort) || t == e + 2) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
        end
        m_ack = '0; m_err = '0; m_rty = '0;
        chk("wb_dat_o", 64'(wb_rdat), 64'(exp_dat));
        chk("timeout_cnt_o", 64'(tocnt), 64'(exp_tocnt));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        // Reset state
        chk("rst m_stb_o", 64'(m_stb), 64'(0));
        chk("rst m_cyc_o", 64'(m_cyc), 64'(0));
        chk("rst ack/err/rty", 64'({wb_ack, wb_err, wb_rty}), 64'(0));
        chk("rst wb_dat_o", 64'(wb_rdat), 64'(0));
        chk("rst timeout_cnt_o", 64'(tocnt), 64'(0));
        chk("rst m_adr/we", 64'({m_adr, m_we}), 64'(0));
        @(posedge clk); #1;

        // Unicast write, ch3 acks two cycles after strobe -> ack at cycle 4.
        clr_cfg(); t_dly[3] = 3;
        run_txn(1'b1, 22'h000C04, 32'h1234_5678, 4'hF, 1'b0);

        // Read from ch5 returning DEADBEEF.
        clr_cfg(); t_dly[5] = 2; t_rdat[5] = 32'hDEAD_BEEF;
        run_txn(1'b0, mk_adr(1'b0, 5, 8'h10), 32'h0, 4'hF, 1'b0);

        // Read of idx 7 is beyond NCHAN=6 -> immediate error, read data held.
        clr_cfg();
        run_txn(1'b0, 22'h001C10, 32'h0, 4'hF, 1'b0);

        // Broadcast write, staggered acks, ch5 errs -> one err after the last.
        clr_cfg();
        for (int k = 0; k < NCH; k++) t_dly[k] = k + 1;
        t_typ[5] = 1;
        run_txn(1'b1, 22'h004008, 32'hA5A5_0001, 4'h3, 1'b0);

        // Write to idx 6 -> no downstream access, err at cycle 1.
        clr_cfg();
        run_txn(1'b1, mk_adr(1'b0, 6, 8'h00), 32'h1, 4'hF, 1'b0);

        // Timeout on ch2.
        clr_cfg();
        run_txn(1'b1, mk_adr(1'b0, 2, 8'h20), 32'h2, 4'hF, 1'b0);

        // Ack exactly in the expiry cycle wins over the timeout.
        clr_cfg(); t_dly[4] = TO;
        run_txn(1'b1, mk_adr(1'b0, 4, 8'h21), 32'h3, 4'hF, 1'b0);

        // Retry response, and a read with the broadcast bit set (unicast).
        clr_cfg(); t_dly[1] = 1; t_typ[1] = 2;
        run_txn(1'b1, mk_adr(1'b0, 1, 8'h30), 32'h4, 4'hF, 1'b0);
        clr_cfg(); t_dly[0] = 4; t_rdat[0] = 32'h0BAD_F00D;
        run_txn(1'b0, mk_adr(1'b1, 0, 8'h31), 32'h0, 4'hF, 1'b1);

        // Abort on the same cycle as ch1 ack -> no response; then a normal access.
        clr_cfg(); t_dly[1] = 3; t_abort = 3;
        run_txn(1'b1, mk_adr(1'b0, 1, 8'h40), 32'h5, 4'hF, 1'b0);
        clr_cfg(); t_dly[1] = 2;
        run_txn(1'b1, mk_adr(1'b0, 1, 8'h41), 32'h6, 4'hF, 1'b0);

        // Reset in the middle of a transaction.
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = mk_adr(1'b0, 1, 8'h50); wb_dat = 32'h7; wb_sel = 4'hF;
        @(posedge clk); #1;
        chk("pre-reset m_stb_o", 64'(m_stb), 64'(6'b000010));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        exp_dat = '0; exp_tocnt = 0;
        chk("midrst m_stb_o", 64'(m_stb), 64'(0));
        chk("midrst ack/err/rty", 64'({wb_ack, wb_err, wb_rty}), 64'(0));
        chk("midrst wb_dat_o", 64'(wb_rdat), 64'(0));
        chk("midrst timeout_cnt_o", 64'(tocnt), 64'(0));
        chk("midrst m_adr/we", 64'({m_adr, m_we}), 64'(0));
        repeat (2) begin
            @(posedge clk); #1;
            chk("post-rst quiet", 64'({m_stb, wb_ack, wb_err, wb_rty}), 64'(0));
        end

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            bit   we, bc;
            int   idx;
            clr_cfg();
            we  = 1'($urandom);
            bc  = ($urandom_range(0, 3) == 0);
            idx = $urandom_range(0, 7);
            for (int k = 0; k < NCH; k++) begin
                t_dly[k] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 18);
                t_typ[k] = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            end
            if ($urandom_range(0, 7) == 0) t_abort = $urandom_range(1, 10);
            run_txn(we, mk_adr(bc, idx, 8'($urandom)), $urandom, 4'($urandom), 1'b1);
        end

        // Timeout counter saturation.
        for (int n = 0; n < 300; n++) begin
            clr_cfg();
            run_txn(1'b1, mk_adr(1'b0, 2, 8'h60), 32'h8, 4'hF, 1'b0);
        end
        chk("timeout_cnt_o saturated", 64'(tocnt), 64'(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
